// File: rtl/fft_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fft_ctrl_pkg
// Shared definitions for the MDC-FFT stage controllers:
//   ctrl_state_e   FSM state encoding (IDLE, FILL, RUN, DRAIN)
//   COM_*          bit positions inside the 7-bit commutator state mask
//   clog2()        ceiling log2, used to derive counter widths
//   com_bit()      one-hot mask with a single COM_* bit set
// ---------------------------------------------------------------------------
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } ctrl_state_e;

    localparam int COM_MASK_W   = 7;
    localparam int COM_BYPASS   = 0;
    localparam int COM_STRAIGHT = 4;
    localparam int COM_CROSS    = 5;
    localparam int COM_DRAIN    = 6;

    // Smallest n with 2**n >= value. The loop stops at 30 so the shift
    // never reaches the sign bit of a 32-bit int.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic logic [COM_MASK_W-1:0] com_bit(input int idx);
        return COM_MASK_W'(1) << idx;
    endfunction

endpackage

// File: rtl/commutator_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// commutator_seq_ctrl_if
// Bundles the sample-stream handshake and the commutator control outputs of
// one MDC-FFT stage sequencer.
//   in_valid   source -> ctrl : sample pair presented this cycle
//   in_last    source -> ctrl : final pair of the stream (qualifies in_valid)
//   mode       ctrl -> stage  : 0 switch, 1 bypass
//   com_mask   ctrl -> stage  : commutator state mask (one-hot or zero)
//   out_valid  ctrl -> stage  : commutator outputs carry valid data
//   busy       ctrl -> status : sequencer not idle
//   done       ctrl -> status : pulse on the last drain cycle
//   overrun    ctrl -> status : pulse when a pair arrives during drain
// Modports: master = stream source / observer, slave = sequencer.
// ---------------------------------------------------------------------------
interface commutator_seq_ctrl_if;
    import fft_ctrl_pkg::*;

    logic                  in_valid;
    logic                  in_last;
    logic                  mode;
    logic [COM_MASK_W-1:0] com_mask;
    logic                  out_valid;
    logic                  busy;
    logic                  done;
    logic                  overrun;

    modport master (
        output in_valid,
        output in_last,
        input  mode,
        input  com_mask,
        input  out_valid,
        input  busy,
        input  done,
        input  overrun
    );

    modport slave (
        input  in_valid,
        input  in_last,
        output mode,
        output com_mask,
        output out_valid,
        output busy,
        output done,
        output overrun
    );

endinterface

// File: rtl/mod_counter.sv
// ---------------------------------------------------------------------------
// mod_counter
// Modulo-MOD up counter with enable and synchronous clear.
//   clk      clock
//   rst      synchronous active-high reset (count -> 0)
//   en_i     count one event this cycle
//   clr_i    restart the count; if en_i is also high the restarting event is
//            counted, so the register lands on 1 rather than 0
//   count_o  current count, 0 .. MOD-1
// ---------------------------------------------------------------------------
module mod_counter #(
    parameter int MOD = 16,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = en_i ? W'(1) : '0;
        end else if (en_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/commutator_seq_ctrl.sv
// ---------------------------------------------------------------------------
// commutator_seq_ctrl
// Sequencer for one MDC-FFT commutator stage. Follows the stream of sample
// pairs entering the stage, fills the delay line, alternates the commutator
// between straight and cross every DELAY accepted pairs, and flushes the
// delay line for DELAY cycles after the last pair.
// Parameters:
//   DELAY   delay-line depth in sample pairs (power of 2, >= 2)
//   CNT_W   pair counter width, derived from DELAY
// Ports:
//   clk     clock, rising edge
//   rst     synchronous active-high reset
//   bus     commutator_seq_ctrl_if.slave (stream in, commutator controls out)
// All outputs are registered: what is seen at cycle t+1 describes the pair
// (or drain step) handled at cycle t.
// ---------------------------------------------------------------------------
module commutator_seq_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int DELAY = 8,
    parameter int CNT_W = clog2(DELAY) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    commutator_seq_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0]      FILL_LAST  = CNT_W'(DELAY - 1);
    localparam logic [CNT_W-1:0]      DRAIN_LAST = CNT_W'(DELAY - 1);
    localparam logic [COM_MASK_W-1:0] MASK_STRAIGHT = com_bit(COM_STRAIGHT);
    localparam logic [COM_MASK_W-1:0] MASK_CROSS    = com_bit(COM_CROSS);
    localparam logic [COM_MASK_W-1:0] MASK_DRAIN    = com_bit(COM_DRAIN);

    ctrl_state_e           state_q;
    logic [CNT_W-1:0]      drain_cnt_q;
    logic                  mode_q;
    logic [COM_MASK_W-1:0] com_mask_q;
    logic                  out_valid_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  overrun_q;

    logic [CNT_W-1:0]      cnt;
    logic                  cnt_en;
    logic                  cnt_clr;
    logic                  phase;

    // Pairs arriving in DRAIN are dropped and must not disturb the count.
    assign cnt_en  = bus.in_valid && (state_q != DRAIN);
    // Holding the counter clear while idle gives every stream a 0 base.
    assign cnt_clr = (state_q == IDLE);

    mod_counter #(
        .MOD (2 * DELAY),
        .W   (CNT_W)
    ) u_pair_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (cnt_en),
        .clr_i   (cnt_clr),
        .count_o (cnt)
    );

    // The fill consumes counts 0..DELAY-1, so the first RUN block sits in the
    // upper half of the 2*DELAY cycle; that block is routed straight, the
    // next one (after the wrap) crossed, and so on alternately.
    assign phase = cnt[CNT_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            mode_q      <= 1'b0;
            com_mask_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            out_valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    mode_q     <= 1'b0;
                    com_mask_q <= '0;
                    busy_q     <= 1'b0;
                    if (bus.in_valid) begin
                        // The first pair already enters the delay line.
                        mode_q <= 1'b1;
                        busy_q <= 1'b1;
                        if (bus.in_last) begin
                            state_q     <= DRAIN;
                            drain_cnt_q <= DRAIN_LAST;
                        end else begin
                            state_q <= FILL;
                        end
                    end
                end

                FILL: begin
                    mode_q     <= 1'b1;
                    com_mask_q <= '0;
                    busy_q     <= 1'b1;
                    if (bus.in_valid) begin
                        if (bus.in_last) begin
                            state_q     <= DRAIN;
                            drain_cnt_q <= DRAIN_LAST;
                        end else if (cnt == FILL_LAST) begin
                            state_q <= RUN;
                        end
                    end
                end

                RUN: begin
                    mode_q <= 1'b0;
                    busy_q <= 1'b1;
                    // During gaps the mask keeps its last value.
                    if (bus.in_valid) begin
                        out_valid_q <= 1'b1;
                        com_mask_q  <= phase ? MASK_STRAIGHT : MASK_CROSS;
                        if (bus.in_last) begin
                            state_q     <= DRAIN;
                            drain_cnt_q <= DRAIN_LAST;
                        end
                    end
                end

                DRAIN: begin
                    mode_q      <= 1'b0;
                    com_mask_q  <= MASK_DRAIN;
                    out_valid_q <= 1'b1;
                    overrun_q   <= bus.in_valid;
                    if (drain_cnt_q == '0) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - CNT_W'(1);
                        busy_q      <= 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.mode      = mode_q;
    assign bus.com_mask  = com_mask_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_commutator_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_commutator_seq_ctrl
// Drives a DELAY=8 and a DELAY=2 sequencer with identical stimulus and
// compares both, every cycle, against a pair-index based reference model.
// Packed observation word per instance (12 bits):
//   [11] mode [10:4] com_mask [3] out_valid [2] busy [1] done [0] overrun
// obs/exp_v hold {instance A (DELAY=8), instance B (DELAY=2)}.
// ---------------------------------------------------------------------------
module tb_commutator_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    commutator_seq_ctrl_if if_a ();
    commutator_seq_ctrl_if if_b ();

    commutator_seq_ctrl #(.DELAY(8)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    commutator_seq_ctrl #(.DELAY(2)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [23:0] obs;
    logic [23:0] exp_v;

    // Reference model state, one slot per instance.
    int         m_pairs [2];
    int         m_drain [2];
    bit         m_live  [2];
    logic [6:0] m_mask  [2];

    // Expected outputs for the cycle after the given inputs, derived from the
    // stream position: pairs before index D fill the delay line, pair p >= D
    // is straight when (p / D) is odd and crossed when even, and after the
    // last pair D drain cycles follow.
    function automatic logic [11:0] model_next(input int k, input int d,
                                               input logic r, input logic v,
                                               input logic l);
        logic       mode, ov, busy, done, ovr;
        logic [6:0] mask;
        mode = 0; mask = 0; ov = 0; busy = 0; done = 0; ovr = 0;
        if (r) begin
            m_pairs[k] = 0; m_drain[k] = 0; m_live[k] = 0; m_mask[k] = 0;
            return 12'h000;
        end
        if (m_drain[k] > 0) begin
            mask = 7'h40; ov = 1; ovr = v;
            done = (m_drain[k] == 1);
            busy = (m_drain[k] > 1);
            m_drain[k]--;
            if (m_drain[k] == 0) begin
                m_pairs[k] = 0; m_live[k] = 0;
            end
        end else if (v) begin
            if (m_pairs[k] < d) begin
                mode = 1;
            end else begin
                ov   = 1;
                mask = (((m_pairs[k] / d) % 2) == 1) ? 7'h10 : 7'h20;
            end
            m_pairs[k]++;
            m_live[k] = 1;
            busy = 1;
            if (l) m_drain[k] = d;
        end else if (m_live[k]) begin
            busy = 1;
            if (m_pairs[k] < d) mode = 1;
            else                mask = m_mask[k];
        end
        m_mask[k] = mask;
        return {mode, mask, ov, busy, done, ovr};
    endfunction

    task automatic cycle(input logic r, input logic v, input logic l);
        rst           = r;
        if_a.in_valid = v; if_a.in_last = l;
        if_b.in_valid = v; if_b.in_last = l;
        exp_v = {model_next(0, 8, r, v, l), model_next(1, 2, r, v, l)};
        @(posedge clk);
        #1;
        obs = {if_a.mode, if_a.com_mask, if_a.out_valid, if_a.busy, if_a.done, if_a.overrun,
               if_b.mode, if_b.com_mask, if_b.out_valid, if_b.busy, if_b.done, if_b.overrun};
        cyc++;
    endtask

    // Mask must be one-hot or zero with the reserved bits clear, always.
    always @(negedge clk) begin
        assert ($onehot0(if_a.com_mask) && (if_a.com_mask[3:1] == 3'b000) &&
                $onehot0(if_b.com_mask) && (if_b.com_mask[3:1] == 3'b000))
        else $error("FAIL com_mask_onehot a=%02h b=%02h", if_a.com_mask, if_b.com_mask);
    end

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1, 0, 0);
            if (obs !== exp_v) begin n_fail++; $display("FAIL reset_model cyc=%0d got=%06h exp=%06h", cyc, obs, exp_v); end
            n_tests++;
        end
        for (int i = 0; i < 12; i++) begin
            cycle(0, 1, 0);
            if (obs !== exp_v) begin n_fail++; $display("FAIL reset_model cyc=%0d got=%06h exp=%06h", cyc, obs, exp_v); end
            n_tests++;
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 0);
            if (obs !== exp_v) begin n_fail++; $display("FAIL reset_model cyc=%0d got=%06h exp=%06h", cyc, obs, exp_v); end
            n_tests++;
            if (obs[23] !== 1'b0 || obs[22:16] !== 7'h00 || obs[14] !== 1'b0 || obs[13] !== 1'b0) begin
                n_fail++; $display("FAIL reset_state cyc=%0d got=%03h exp=000", cyc, obs[23:12]);
            end
            n_tests++;
        end
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0);
            if (obs[13] !== 1'b0 || obs[14] !== 1'b0) begin
                n_fail++; $display("FAIL reset_no_done cyc=%0d got done=%b busy=%b exp 0 0", cyc, obs[13], obs[14]);
            end
            n_tests++;
        end
        $display("[TB] test_reset complete at cycle %0d", cyc);
    endtask

    task automatic test_continuous();
        logic [6:0] blk_tab [4] = '{7'h00, 7'h10, 7'h20, 7'h10};
        int drains, dones;
        drains = 0; dones = 0;
        cycle(1, 0, 0);
        for (int i = 0; i < 32; i++) begin
            cycle(0, 1, i == 31);
            if (obs !== exp_v) begin n_fail++; $display("FAIL cont_model cyc=%0d got=%06h exp=%06h", cyc, obs, exp_v); end
            n_tests++;
            if (obs[22:16] !== blk_tab[i / 8] || obs[23] !== (i < 8)) begin
                n_fail++; $display("FAIL cont_seq pair=%0d got mode=%b mask=%02h exp mode=%b mask=%02h",
                                   i, obs[23], obs[22:16], (i < 8), blk_tab[i / 8]);
            end
            n_tests++;
        end
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 0);
            if (obs !== exp_v) begin n_fail++; $display("FAIL cont_model cyc=%0d got=%06h exp=%06h", cyc, obs, exp_v); end
            n_tests++;
            if (obs[22:16] == 7'h40 && obs[15]) drains++;
            if (obs[13]) dones++;
            if (i == 7 && obs[13] !== 1'b1) begin
                n_fail++; $display("FAIL cont_done_pos got=%b exp=1", obs[13]);
            end
            if (i == 7) n_tests++;
        end
        if (drains != 8 || dones != 1 || obs[14] !== 1'b0) begin
            n_fail++; $display("FAIL cont_drain got drains=%0d dones=%0d busy=%b exp 8 1 0", drains, dones, obs[14]);
        end
        n_tests++;
        $display("[TB] test_continuous complete at cycle %0d", cyc);
    endtask

    task automatic test_gapped();
        logic [6:0] held;
        cycle(1, 0, 0);
        for (int p = 0; p < 11; p++) begin
            cycle(0, 1, 0);
            if (obs !== exp_v) begin n_fail++; $display("FAIL gap_model cyc=%0d got=%06h exp=%06h", cyc, obs, exp_v); end
            n_tests++;
        end
        held = obs[22:16];
        if (held !== 7'h10) begin n_fail++; $display("FAIL gap_premask got=%02h exp=10", held); end
        n_tests++;
        for (int g = 0; g < 3; g++) begin
            cycle(0, 0, 0);
            if (obs !== exp_v) begin n_fail++; $display("FAIL gap_model cyc=%0d got=%06h exp=%06h", cyc, obs, exp_v); end
            n_tests++;
            if (obs[22:16] !== held || obs[15] !== 1'b0) begin
                n_fail++; $display("FAIL gap_hold cyc=%0d got mask=%02h ov=%b exp mask=%02h ov=0", cyc, obs[22:16], obs[15], held);
            end
            n_tests++;
        end
        for (int p = 11; p < 16; p++) begin
            cycle(0, 1, 0);
            if (obs !== exp_v) begin n_fail++; $display("FAIL gap_model cyc=%0d got=%06h exp=%06h", cyc, obs, exp_v); end
            n_tests++;
            if (obs[22:16] !== held) begin
                n_fail++; $display("FAIL gap_early_flip pair=%0d got=%02h exp=%02h", p, obs[22:16], held);
            end
            n_tests++;
        end
        cycle(0, 1, 0);
        if (obs[22:16] !== 7'h20) begin n_fail++; $display("FAIL gap_flip got=%02h exp=20", obs[22:16]); end
        n_tests++;
        cycle(0, 1, 1);
        if (obs !== exp_v) begin n_fail++; $display("FAIL gap_model cyc=%0d got=%06h exp=%06h", cyc, obs, exp_v); end
        n_tests++;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 0);
            if (obs !== exp_v) begin n_fail++; $display("FAIL gap_model cyc=%0d got=%06h exp=%06h", cyc, obs, exp_v); end
            n_tests++;
        end
        $display("[TB] test_gapped complete at cycle %0d", cyc);
    endtask

    task automatic test_short();
        int drains, dones;
        cycle(1, 0, 0);
        for (int s = 0; s < 2; s++) begin
            // s=0: three-pair stream, s=1: single pair with in_last
            drains = 0; dones = 0;
            for (int p = 0; p < (s == 0 ? 3 : 1); p++) begin
                cycle(0, 1, p == (s == 0 ? 2 : 0));
                if (obs !== exp_v) begin n_fail++; $display("FAIL short_model cyc=%0d got=%06h exp=%06h", cyc, obs, exp_v); end
                n_tests++;
            end
            for (int i = 0; i < 10; i++) begin
                cycle(0, 0, 0);
                if (obs !== exp_v) begin n_fail++; $display("FAIL short_model cyc=%0d got=%06h exp=%06h", cyc, obs, exp_v); end
                n_tests++;
                if (obs[22:16] == 7'h40 && obs[15]) drains++;
                if (obs[13]) dones++;
            end
            if (drains != 8 || dones != 1) begin
                n_fail++; $display("FAIL short_drain stream=%0d got drains=%0d dones=%0d exp 8 1", s, drains, dones);
            end
            n_tests++;
        end
        $display("[TB] test_short complete at cycle %0d", cyc);
    endtask

    task automatic test_overrun();
        int ovrs;
        ovrs = 0;
        cycle(1, 0, 0);
        for (int p = 0; p < 10; p++) begin
            cycle(0, 1, p == 9);
            if (obs !== exp_v) begin n_fail++; $display("FAIL ovr_model cyc=%0d got=%06h exp=%06h", cyc, obs, exp_v); end
            n_tests++;
        end
        for (int d = 1; d <= 8; d++) begin
            cycle(0, (d == 2 || d == 5), 0);
            if (obs !== exp_v) begin n_fail++; $display("FAIL ovr_model cyc=%0d got=%06h exp=%06h", cyc, obs, exp_v); end
            n_tests++;
            if (obs[12] !== (d == 2 || d == 5) || obs[22:16] !== 7'h40 || obs[13] !== (d == 8)) begin
                n_fail++; $display("FAIL ovr_drain d=%0d got ovr=%b mask=%02h done=%b exp ovr=%b mask=40 done=%b",
                                   d, obs[12], obs[22:16], obs[13], (d == 2 || d == 5), (d == 8));
            end
            n_tests++;
            if (obs[12]) ovrs++;
        end
        if (ovrs != 2) begin n_fail++; $display("FAIL ovr_count got=%0d exp=2", ovrs); end
        n_tests++;
        for (int p = 0; p < 12; p++) begin
            cycle(0, 1, p == 11);
            if (obs !== exp_v) begin n_fail++; $display("FAIL ovr_model cyc=%0d got=%06h exp=%06h", cyc, obs, exp_v); end
            n_tests++;
            if (p == 0 && (obs[23] !== 1'b1 || obs[14] !== 1'b1)) begin
                n_fail++; $display("FAIL b2b_fill got mode=%b busy=%b exp 1 1", obs[23], obs[14]);
            end
            if (p == 0) n_tests++;
        end
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 0);
            if (obs !== exp_v) begin n_fail++; $display("FAIL ovr_model cyc=%0d got=%06h exp=%06h", cyc, obs, exp_v); end
            n_tests++;
        end
        $display("[TB] test_overrun complete at cycle %0d", cyc);
    endtask

    task automatic test_delay2();
        logic [6:0] seq_tab [10] = '{7'h00, 7'h00, 7'h10, 7'h10, 7'h20, 7'h20, 7'h10, 7'h10, 7'h40, 7'h40};
        cycle(1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            cycle(0, i < 8, i == 7);
            if (obs !== exp_v) begin n_fail++; $display("FAIL d2_model cyc=%0d got=%06h exp=%06h", cyc, obs, exp_v); end
            n_tests++;
            if (i < 10) begin
                if (obs[10:4] !== seq_tab[i] || obs[11] !== (i < 2) || obs[1] !== (i == 9)) begin
                    n_fail++; $display("FAIL d2_seq i=%0d got mode=%b mask=%02h done=%b exp mode=%b mask=%02h done=%b",
                                       i, obs[11], obs[10:4], obs[1], (i < 2), seq_tab[i], (i == 9));
                end
                n_tests++;
            end
        end
        $display("[TB] test_delay2 complete at cycle %0d", cyc);
    endtask

    task automatic test_random();
        logic r, v, l;
        cycle(1, 0, 0);
        for (int i = 0; i < 800; i++) begin
            r = ($urandom_range(0, 299) == 0);
            v = ($urandom_range(0, 9) < 7);
            l = v && ($urandom_range(0, 19) == 0);
            cycle(r, v, l);
            if (obs !== exp_v) begin n_fail++; $display("FAIL rand_model cyc=%0d got=%06h exp=%06h", cyc, obs, exp_v); end
            n_tests++;
        end
        for (int i = 0; i < 12; i++) begin
            cycle(0, 0, 0);
            if (obs !== exp_v) begin n_fail++; $display("FAIL rand_model cyc=%0d got=%06h exp=%06h", cyc, obs, exp_v); end
            n_tests++;
        end
        $display("[TB] test_random complete at cycle %0d", cyc);
    endtask

    initial begin
        if_a.in_valid = 1'b0; if_a.in_last = 1'b0;
        if_b.in_valid = 1'b0; if_b.in_last = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_pairs[k] = 0; m_drain[k] = 0; m_live[k] = 0; m_mask[k] = 0;
        end
        test_reset();
        test_continuous();
        test_gapped();
        test_short();
        test_overrun();
        test_delay2();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
